// File: rtl/sprite_motion_host.sv
// Host-side initiator for the sprite unit's host RAM port.
// Advances a shadow motion table and commits it to staging on request.
module sprite_motion_host #(
  parameter int MAX_SPRITES = 8,
  parameter int LOGIC_W     = 256,
  parameter int LOGIC_H     = 192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        bitmap_wen,
  input  logic        user_interrupt,
  input  logic        cfg_we,
  input  logic        cfg_sel,
  input  logic [2:0]  cfg_idx,
  input  logic [31:0] cfg_data,
  output logic [5:0]  address,
  output logic [31:0] data_out,
  output logic [1:0]  data_write_n,
  output logic [1:0]  data_read_n,
  output logic        busy,
  output logic        done,
  output logic [7:0]  overrun_cnt
);

  localparam int IW = (MAX_SPRITES > 1) ? $clog2(MAX_SPRITES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    COMMIT
  } state_t;

  state_t state, state_d;

  logic [IW-1:0] idx_q;
  logic [7:0]    pos_x    [MAX_SPRITES];
  logic [7:0]    pos_y    [MAX_SPRITES];
  logic [7:0]    bm_off   [MAX_SPRITES];
  logic [7:0]    spr_size [MAX_SPRITES];
  logic [7:0]    vel_x    [MAX_SPRITES];
  logic [7:0]    vel_y    [MAX_SPRITES];

  logic        req;
  logic        cfg_ok;
  logic        last;
  logic [4:0]  w_x, w_y;
  logic [9:0]  lim_x, lim_y;
  logic [15:0] mv_x, mv_y;

  assign req    = user_interrupt && enable;
  assign cfg_ok = cfg_we && (state == IDLE) && !busy && !req &&
                  ({29'd0, cfg_idx} < 32'(MAX_SPRITES));
  assign last   = (idx_q == IW'(MAX_SPRITES - 1));

  assign data_read_n = 2'b11;

  // Returns {new_pos, new_vel}; -128 reflects to +127.
  function automatic logic [15:0] step(
    input logic [7:0] p,
    input logic [7:0] v,
    input logic [9:0] lim
  );
    logic signed [9:0] n;
    logic [7:0]        nv;
    logic [15:0]       r;
    n  = $signed({2'b00, p}) + $signed({{2{v[7]}}, v});
    nv = (v == 8'h80) ? 8'h7f : (~v + 8'd1);
    if (v == 8'h00)
      r = {p, v};
    else if (n < 0)
      r = {8'h00, nv};
    else if (n > $signed(lim))
      r = {lim[7:0], nv};
    else
      r = {n[7:0], v};
    return r;
  endfunction

  always_comb begin
    w_x   = {1'b0, spr_size[idx_q][7:4]} + 5'd1;
    w_y   = {1'b0, spr_size[idx_q][3:0]} + 5'd1;
    lim_x = 10'(LOGIC_W) - {5'd0, w_x};
    lim_y = 10'(LOGIC_H) - {5'd0, w_y};
    mv_x  = step(pos_x[idx_q], vel_x[idx_q], lim_x);
    mv_y  = step(pos_y[idx_q], vel_y[idx_q], lim_y);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_d;
  end

  // IDLE with busy still set is the finishing cycle after COMMIT.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (req && !busy) state_d = WRITE;
      WRITE:   if (last) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      address      <= 6'd0;
      data_out     <= 32'd0;
      data_write_n <= 2'b11;
      busy         <= 1'b0;
      done         <= 1'b0;
      overrun_cnt  <= 8'd0;
      idx_q        <= '0;
    end else begin
      done <= 1'b0;
      if (req && busy && (overrun_cnt != 8'hff))
        overrun_cnt <= overrun_cnt + 8'd1;
      unique case (state)
        IDLE: begin
          data_write_n <= 2'b11;
          if (busy) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else if (req) begin
            busy  <= 1'b1;
            idx_q <= '0;
          end
        end
        WRITE: begin
          address      <= 6'({idx_q, 2'b00});
          data_out     <= {spr_size[idx_q], bm_off[idx_q],
                           mv_y[15:8], mv_x[15:8]};
          data_write_n <= 2'b10;
          idx_q        <= idx_q + 1'b1;
        end
        COMMIT: begin
          address      <= 6'd63;
          data_out     <= {30'd0, 1'b1, bitmap_wen};
          data_write_n <= 2'b00;
        end
        default: data_write_n <= 2'b11;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MAX_SPRITES; k++) begin
        pos_x[k]    <= 8'd0;
        pos_y[k]    <= 8'd0;
        bm_off[k]   <= 8'd0;
        spr_size[k] <= 8'd0;
        vel_x[k]    <= 8'd0;
        vel_y[k]    <= 8'd0;
      end
    end else if (state == WRITE) begin
      pos_x[idx_q] <= mv_x[15:8];
      vel_x[idx_q] <= mv_x[7:0];
      pos_y[idx_q] <= mv_y[15:8];
      vel_y[idx_q] <= mv_y[7:0];
    end else if (cfg_ok) begin
      if (!cfg_sel) begin
        spr_size[cfg_idx] <= cfg_data[31:24];
        bm_off[cfg_idx]   <= cfg_data[23:16];
        pos_y[cfg_idx]    <= cfg_data[15:8];
        pos_x[cfg_idx]    <= cfg_data[7:0];
      end else begin
        vel_y[cfg_idx] <= cfg_data[15:8];
        vel_x[cfg_idx] <= cfg_data[7:0];
      end
    end
  end

endmodule

// File: tb/tb_sprite_motion_host.sv
// Scoreboard bench for sprite_motion_host.
// Expected bus writes come from an independent motion model.
module tb_sprite_motion_host;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        bitmap_wen;
  logic        user_interrupt;
  logic        cfg_we;
  logic        cfg_sel;
  logic [2:0]  cfg_idx;
  logic [31:0] cfg_data;
  logic [5:0]  address;
  logic [31:0] data_out;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic        busy;
  logic        done;
  logic [7:0]  overrun_cnt;

  sprite_motion_host dut (
    .clk(clk), .rst(rst), .enable(enable),
    .bitmap_wen(bitmap_wen), .user_interrupt(user_interrupt),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx),
    .cfg_data(cfg_data), .address(address), .data_out(data_out),
    .data_write_n(data_write_n), .data_read_n(data_read_n),
    .busy(busy), .done(done), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
    logic [1:0]  wn;
    int          c;
  } exp_t;

  exp_t sb[$];
  exp_t me;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int seen63 = 0;
  int wr_seen = 0;
  bit mon_en = 1'b1;
  logic [31:0] last_word [16];
  logic [31:0] last_ctl;

  int mx[N], my[N], moff[N], msz[N], mvx[N], mvy[N];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst === 1'b0 && data_write_n !== 2'b11) begin
      wr_seen++;
      if (address == 6'd63) begin
        seen63++;
        last_ctl = data_out;
      end else begin
        last_word[address[5:2]] = data_out;
      end
      if (mon_en) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got a=%0d d=%h wn=%b cyc=%0d, none required",
                   address, data_out, data_write_n, cyc);
        end else begin
          me = sb.pop_front();
          if (address !== me.a || data_out !== me.d ||
              data_write_n !== me.wn || cyc !== me.c) begin
            errors++;
            $display("FAIL bus_write: got a=%0d d=%h wn=%b cyc=%0d want a=%0d d=%h wn=%b cyc=%0d",
                     address, data_out, data_write_n, cyc,
                     me.a, me.d, me.wn, me.c);
          end
        end
      end
    end
  end

  function automatic int negv(int v);
    return (v == -128) ? 127 : -v;
  endfunction

  function automatic int newpos(int p, int v, int lim);
    int n;
    if (v == 0) return p;
    n = p + v;
    if (n < 0) return 0;
    if (n > lim) return lim;
    return n;
  endfunction

  function automatic int newvel(int p, int v, int lim);
    int n;
    if (v == 0) return 0;
    n = p + v;
    if (n < 0 || n > lim) return negv(v);
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      mx[i] = 0; my[i] = 0; moff[i] = 0;
      msz[i] = 0; mvx[i] = 0; mvy[i] = 0;
    end
  endtask

  task automatic cfg_write(int i, bit sel, logic [31:0] d);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_sel = sel;
    cfg_idx = 3'(i);
    cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
    if (!sel) begin
      msz[i] = int'(d[31:24]);
      moff[i] = int'(d[23:16]);
      my[i] = int'(d[15:8]);
      mx[i] = int'(d[7:0]);
    end else begin
      mvy[i] = int'($signed(d[15:8]));
      mvx[i] = int'($signed(d[7:0]));
    end
  endtask

  task automatic start_seq(bit bw);
    exp_t e;
    int xl, yl, np;
    bitmap_wen = bw;
    @(negedge clk);
    user_interrupt = 1'b1;
    t0 = cyc + 1;
    for (int i = 0; i < N; i++) begin
      xl = 256 - ((msz[i] >> 4) + 1);
      yl = 192 - ((msz[i] & 15) + 1);
      np = newpos(mx[i], mvx[i], xl);
      mvx[i] = newvel(mx[i], mvx[i], xl);
      mx[i] = np;
      np = newpos(my[i], mvy[i], yl);
      mvy[i] = newvel(my[i], mvy[i], yl);
      my[i] = np;
      e.a = 6'(4 * i);
      e.d = {8'(msz[i]), 8'(moff[i]), 8'(my[i]), 8'(mx[i])};
      e.wn = 2'b10;
      e.c = t0 + 1 + i;
      sb.push_back(e);
    end
    e.a = 6'd63;
    e.d = {30'd0, 1'b1, bw};
    e.wn = 2'b00;
    e.c = t0 + N + 1;
    sb.push_back(e);
    @(negedge clk);
    user_interrupt = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_start: got %b want 1", busy);
    end
  endtask

  task automatic wait_done();
    int dc;
    dc = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dc = cyc;
        break;
      end
    end
    checks++;
    if (dc != t0 + N + 2) begin
      errors++;
      $display("FAIL done_cycle: got %0d want %0d", dc, t0 + N + 2);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_end: got %b want 0", busy);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_writes: got %0d left want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (address !== 6'd0 || data_out !== 32'd0 || data_write_n !== 2'b11 ||
        data_read_n !== 2'b11 || busy !== 1'b0 || done !== 1'b0 ||
        overrun_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: got a=%0d d=%h wn=%b rn=%b busy=%b done=%b ovr=%0d want all idle",
               address, data_out, data_write_n, data_read_n,
               busy, done, overrun_cnt);
    end
    rst = 1'b0;
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_basic();
    cfg_write(0, 1'b0, 32'h3300_140A);
    cfg_write(0, 1'b1, 32'h0000_FF02);
    start_seq(1'b0);
    wait_done();
    checks++;
    if (last_word[0] !== 32'h3300130C) begin
      errors++;
      $display("FAIL basic_word0: got %h want 3300130c", last_word[0]);
    end
    checks++;
    if (last_ctl !== 32'h2) begin
      errors++;
      $display("FAIL basic_ctl: got %h want 00000002", last_ctl);
    end
  endtask

  task automatic test_edges();
    cfg_write(1, 1'b0, 32'h7000_00FA);
    cfg_write(1, 1'b1, 32'h0000_0003);
    cfg_write(2, 1'b0, 32'h0000_0100);
    cfg_write(2, 1'b1, 32'h0000_FC00);
    cfg_write(3, 1'b0, 32'h0300_BC00);
    cfg_write(3, 1'b1, 32'h0000_0500);
    start_seq(1'b0);
    wait_done();
    checks++;
    if (last_word[1][7:0] !== 8'd248) begin
      errors++;
      $display("FAIL right_bounce: got %0d want 248", last_word[1][7:0]);
    end
    checks++;
    if (last_word[2][15:8] !== 8'd0) begin
      errors++;
      $display("FAIL top_bounce: got %0d want 0", last_word[2][15:8]);
    end
    checks++;
    if (last_word[3][15:8] !== 8'd188) begin
      errors++;
      $display("FAIL bottom_bounce: got %0d want 188", last_word[3][15:8]);
    end
    start_seq(1'b0);
    wait_done();
    checks++;
    if (last_word[1][7:0] !== 8'd245) begin
      errors++;
      $display("FAIL right_after: got %0d want 245", last_word[1][7:0]);
    end
    checks++;
    if (last_word[2][15:8] !== 8'd4) begin
      errors++;
      $display("FAIL top_after: got %0d want 4", last_word[2][15:8]);
    end
    checks++;
    if (last_word[3][15:8] !== 8'd183) begin
      errors++;
      $display("FAIL bottom_after: got %0d want 183", last_word[3][15:8]);
    end
  endtask

  task automatic test_enable_gate();
    int w0;
    logic [7:0] o0;
    w0 = wr_seen;
    o0 = overrun_cnt;
    enable = 1'b0;
    @(negedge clk);
    user_interrupt = 1'b1;
    @(negedge clk);
    user_interrupt = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (wr_seen != w0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL enable_gate: got writes=%0d busy=%b want writes=%0d busy=0",
               wr_seen, busy, w0);
    end
    checks++;
    if (overrun_cnt !== o0) begin
      errors++;
      $display("FAIL enable_ovr: got %0d want %0d", overrun_cnt, o0);
    end
    enable = 1'b1;
  endtask

  task automatic test_bitmap_wen();
    start_seq(1'b1);
    wait_done();
    bitmap_wen = 1'b0;
    checks++;
    if (last_ctl !== 32'h3) begin
      errors++;
      $display("FAIL bitmap_ctl: got %h want 00000003", last_ctl);
    end
  endtask

  task automatic test_overrun();
    start_seq(1'b0);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_sel = 1'b0;
    cfg_idx = 3'd0;
    cfg_data = 32'h1111_6464;
    @(negedge clk);
    cfg_we = 1'b0;
    user_interrupt = 1'b1;
    @(negedge clk);
    user_interrupt = 1'b0;
    wait_done();
    checks++;
    if (overrun_cnt !== 8'd1) begin
      errors++;
      $display("FAIL overrun_one: got %0d want 1", overrun_cnt);
    end
    repeat (4) @(negedge clk);
    start_seq(1'b0);
    wait_done();
  endtask

  task automatic test_saturate();
    mon_en = 1'b0;
    @(negedge clk);
    user_interrupt = 1'b1;
    repeat (500) @(negedge clk);
    user_interrupt = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    checks++;
    if (overrun_cnt !== 8'd255 || busy !== 1'b0) begin
      errors++;
      $display("FAIL overrun_sat: got %0d busy=%b want 255 busy=0",
               overrun_cnt, busy);
    end
  endtask

  task automatic test_async_reset();
    mon_en = 1'b0;
    repeat (3) @(negedge clk);
    seen63 = 0;
    user_interrupt = 1'b1;
    @(negedge clk);
    user_interrupt = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (data_write_n !== 2'b11 || busy !== 1'b0 || overrun_cnt !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: got wn=%b busy=%b ovr=%0d want 11 0 0",
               data_write_n, busy, overrun_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (20) @(negedge clk);
    checks++;
    if (seen63 != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL no_commit: got ctl_writes=%0d busy=%b want 0 0",
               seen63, busy);
    end
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b1;
    bitmap_wen = 1'b0;
    user_interrupt = 1'b0;
    cfg_we = 1'b0;
    cfg_sel = 1'b0;
    cfg_idx = 3'd0;
    cfg_data = 32'd0;
    last_ctl = 32'hdead_beef;
    for (int i = 0; i < 16; i++) last_word[i] = 32'hdead_beef;
    test_reset();
    test_basic();
    test_edges();
    test_enable_gate();
    test_bitmap_wen();
    test_overrun();
    test_saturate();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
